tlc1543_scan_avg: RTL and testbench

Channel sequencer and averager downstream of the TLC1543 serial driver. It issues conversion requests round-robin over channels 0..N_CH-1 and collects 2^AVG_LOG2 samples per channel. It stores the truncated mean of each channel in a result bank and pulses frame_done after each complete sweep. It is the sample producer for the rest of the acquisition path.

---
 rtl/tlc1543_pkg.sv | 23 ++
 rtl/tlc1543_timeout_cnt.sv | 42 ++++
 rtl/tlc1543_scan_avg.sv | 170 +++++++++++++++++
 tb/tb_tlc1543_scan_avg.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc1543_pkg.sv
// rtl/tlc1543_pkg.sv - shared widths, channel limit and FSM encoding for the TLC1543 scan path
package tlc1543_pkg;

  localparam int ADC_W          = 10;
  localparam int CHAN_W         = 4;
  localparam int TLC1543_MAX_CH = 11;

  typedef enum logic [2:0] {
    SCAN_IDLE  = 3'd0,
    SCAN_REQ   = 3'd1,
    SCAN_WAIT  = 3'd2,
    SCAN_STORE = 3'd3,
    SCAN_NEXT  = 3'd4
  } scan_state_e;

  // Plain vectors so the state register stays a legacy-friendly logic [2:0]
  localparam logic [2:0] ST_IDLE  = SCAN_IDLE;
  localparam logic [2:0] ST_REQ   = SCAN_REQ;
  localparam logic [2:0] ST_WAIT  = SCAN_WAIT;
  localparam logic [2:0] ST_STORE = SCAN_STORE;
  localparam logic [2:0] ST_NEXT  = SCAN_NEXT;

endpackage

// File: rtl/tlc1543_timeout_cnt.sv
// rtl/tlc1543_timeout_cnt.sv - loadable down-counter with clear and one-shot expire
module tlc1543_timeout_cnt #(
  parameter int unsigned LOAD_VAL = 50000
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (LOAD_VAL > 1) ? $clog2(LOAD_VAL) : 1;
  // Loading LOAD_VAL-1 makes expire fire on the LOAD_VAL-th enabled cycle
  localparam logic [CNT_W-1:0] LOAD_M1 = CNT_W'(LOAD_VAL - 1);

  logic [CNT_W-1:0] cnt;
  logic             armed;

  assign expire = armed & en & (cnt == '0);

  // Count down while armed; disarm on expiry so only one pulse is produced
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= LOAD_M1;
      armed <= 1'b1;
    end else if (en && armed) begin
      if (cnt == '0) begin
        armed <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tlc1543_scan_avg.sv
// rtl/tlc1543_scan_avg.sv - round-robin channel sequencer and averager; TLC1543_SCAN_THRESH_EN adds the alarm compare
module tlc1543_scan_avg
  import tlc1543_pkg::*;
#(
  parameter int N_CH        = 11,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 50000
`ifdef TLC1543_SCAN_THRESH_EN
  , parameter logic [ADC_W-1:0] THRESH = 10'd900
`endif
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic              conv_busy,
  output logic              conv_req,
  output logic [CHAN_W-1:0] conv_chan,
  input  logic              conv_done,
  input  logic [ADC_W-1:0]  conv_data,
  input  logic [CHAN_W-1:0] rd_chan,
  output logic [ADC_W-1:0]  rd_data,
  output logic              frame_done,
  output logic              timeout_err
`ifdef TLC1543_SCAN_THRESH_EN
  , output logic [N_CH-1:0] alarm
`endif
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(N_CH - 1);

  logic [2:0]        state;
  logic [CHAN_W-1:0] chan;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [ADC_W-1:0]  bank [N_CH];
  logic [ADC_W-1:0]  mean;
  logic [ADC_W-1:0]  rd_next;
  logic              to_load;
  logic              to_clr;
  logic              to_en;
  logic              to_expire;

  // Dropping the low AVG_LOG2 bits is the truncating divide
  assign mean      = acc[ACC_W-1:AVG_LOG2];
  assign conv_chan = chan;

  assign to_load = (state == ST_REQ) && scan_en && !conv_busy;
  assign to_en   = (state == ST_WAIT);
  assign to_clr  = (state == ST_WAIT) && conv_done;

  tlc1543_timeout_cnt #(
    .LOAD_VAL (TIMEOUT_CYC)
  ) u_timeout (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .clr     (to_clr),
    .load    (to_load),
    .en      (to_en),
    .expire  (to_expire)
  );

  // Sweep sequencer: request, collect, store, advance channel
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      chan        <= '0;
      cnt         <= '0;
      acc         <= '0;
      conv_req    <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      conv_req    <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          chan <= '0;
          cnt  <= '0;
          acc  <= '0;
          if (scan_en) state <= ST_REQ;
        end
        ST_REQ: begin
          if (!scan_en) begin
            state <= ST_IDLE;
          end else if (!conv_busy) begin
            conv_req <= 1'b1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // conv_done has priority over a simultaneous expiry
          if (conv_done) begin
            acc <= acc + ACC_W'(conv_data);
            if (cnt == CNT_LAST) begin
              // An abort during the last sample skips STORE; REQ then falls to IDLE
              state <= scan_en ? ST_STORE : ST_REQ;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              state <= ST_REQ;
            end
          end else if (to_expire) begin
            timeout_err <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_STORE: begin
          acc   <= '0;
          cnt   <= '0;
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (chan == CHAN_LAST) begin
            frame_done <= 1'b1;
            chan       <= '0;
          end else begin
            chan <= chan + CHAN_W'(1);
          end
          state <= scan_en ? ST_REQ : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result bank: one register per channel, written only in STORE
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) bank[i] <= '0;
    end else if (state == ST_STORE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (chan == CHAN_W'(i)) bank[i] <= mean;
      end
    end
  end

`ifdef TLC1543_SCAN_THRESH_EN
  // Per-channel over-threshold flag, refreshed alongside the bank entry
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= '0;
    end else if (state == ST_STORE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (chan == CHAN_W'(i)) alarm[i] <= (mean > THRESH);
      end
    end
  end
`endif

  // Read mux; addresses at or beyond N_CH read as zero
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_chan == CHAN_W'(i)) rd_next = bank[i];
    end
  end

  // Registered read port
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_tlc1543_scan_avg.sv
// tb/tb_tlc1543_scan_avg.sv - randomized driver model and sample-list reference for tlc1543_scan_avg
module tb_tlc1543_scan_avg;

  localparam int N_CH     = 3;
  localparam int AVG_LOG2 = 2;
  localparam int NS       = 1 << AVG_LOG2;
  localparam int TO       = 300;
  localparam int THRESH   = 900;

  logic       clk_50m = 1'b0;
  logic       rst_n;
  logic       scan_en;
  logic       conv_busy;
  logic       conv_req;
  logic [3:0] conv_chan;
  logic       conv_done;
  logic [9:0] conv_data;
  logic [3:0] rd_chan;
  logic [9:0] rd_data;
  logic       frame_done;
  logic       timeout_err;
`ifdef TLC1543_SCAN_THRESH_EN
  logic [N_CH-1:0] alarm;
`endif

  tlc1543_scan_avg #(
    .N_CH        (N_CH),
    .AVG_LOG2    (AVG_LOG2),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .conv_busy   (conv_busy),
    .conv_req    (conv_req),
    .conv_chan   (conv_chan),
    .conv_done   (conv_done),
    .conv_data   (conv_data),
    .rd_chan     (rd_chan),
    .rd_data     (rd_data),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
`ifdef TLC1543_SCAN_THRESH_EN
    , .alarm     (alarm)
`endif
  );

  always #10 clk_50m = ~clk_50m;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk_50m) cyc <= cyc + 1;

  int frames = 0;
  int tos = 0;
  int dones = 0;
  int to_cyc = 0;

  always @(negedge clk_50m) begin
    if (frame_done) frames <= frames + 1;
    if (conv_done) dones <= dones + 1;
    if (timeout_err) begin
      tos    <= tos + 1;
      to_cyc <= cyc;
    end
  end

  // Controls written only by the stimulus process
  int data_mode = 0;
  int const_val = 0;
  int drop_ch = -1;
  int drop_token = 0;
  int clr_token = 0;
  int seq_token = 0;
  int seq_v [4];

  // Driver-owned state and reference model
  int drop_seen = 0;
  int clr_seen = 0;
  int seq_seen = 0;
  int seq_q [$];
  int samp [N_CH][$];
  int exp_bank [N_CH];
  int exp_frames = 0;
  int exp_tos = 0;
  int reqs = 0;
  int last_req_cyc = 0;
  int drop_req_cyc = 0;
  int rereq_ch = -1;
  bit after_drop = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Converter driver: answers each conv_req after 1..4 cycles and folds the sample into the model
  initial begin : driver
    int ch;
    int lat;
    int v;
    int sum;
    conv_done = 1'b0;
    conv_data = '0;
    forever begin
      @(posedge clk_50m); #1;
      if (!rst_n) begin
        for (int c = 0; c < N_CH; c++) begin
          samp[c].delete();
          exp_bank[c] = 0;
        end
        seq_q.delete();
      end else begin
        if (clr_token != clr_seen) begin
          clr_seen = clr_token;
          for (int c = 0; c < N_CH; c++) samp[c].delete();
        end
        if (seq_token != seq_seen) begin
          seq_seen = seq_token;
          seq_q.delete();
          for (int k = 0; k < 4; k++) seq_q.push_back(seq_v[k]);
        end
        if (conv_req) begin
          ch = int'(conv_chan);
          reqs++;
          last_req_cyc = cyc;
          if (after_drop) begin
            rereq_ch   = ch;
            after_drop = 1'b0;
          end
          if (drop_token != drop_seen && ch == drop_ch) begin
            drop_seen    = drop_token;
            drop_req_cyc = cyc;
            after_drop   = 1'b1;
            exp_tos++;
          end else begin
            lat = $urandom_range(1, 4);
            repeat (lat - 1) begin
              @(posedge clk_50m); #1;
            end
            if (seq_q.size() > 0) v = seq_q.pop_front();
            else if (data_mode == 1) v = const_val;
            else v = $urandom_range(0, 1023);
            conv_done = 1'b1;
            conv_data = 10'(v);
            @(posedge clk_50m); #1;
            conv_done = 1'b0;
            conv_data = 10'($urandom_range(0, 1023));
            samp[ch].push_back(v);
            if (samp[ch].size() == NS) begin
              sum = 0;
              for (int k = 0; k < NS; k++) sum += samp[ch][k];
              exp_bank[ch] = sum / NS;
              samp[ch].delete();
              if (ch == N_CH - 1) exp_frames++;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_50m); #2;
  endtask

  task automatic rd_bank(input int c, output int v);
    rd_chan = 4'(c);
    step();
    v = int'(rd_data);
  endtask

  task automatic chk_bank(input string tag);
    int v;
    for (int c = 0; c < N_CH; c++) begin
      rd_bank(c, v);
      check_eq($sformatf("%s_bank%0d", tag, c), v, exp_bank[c]);
`ifdef TLC1543_SCAN_THRESH_EN
      check_eq($sformatf("%s_alarm%0d", tag, c), int'(alarm[c]), int'(exp_bank[c] > THRESH));
`endif
    end
  endtask

  task automatic run_frames(input int n, input string tag);
    int got;
    int b;
    got = 0;
    b = 0;
    scan_en = 1'b1;
    while (got < n && b < 1000 * n + 2 * TO) begin
      step();
      b++;
      if (frame_done) got++;
    end
    scan_en = 1'b0;
    check_eq({tag, "_frames"}, got, n);
    repeat (10) step();
  endtask

  initial begin : watchdog
    repeat (50000) @(posedge clk_50m);
    $display("FAIL watchdog got=%0d exp=%0d", cyc, 0);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int f0, d0, ef0, t0, et0, r0, r1, fall, b, v, prev2;
    rst_n     = 1'b0;
    scan_en   = 1'b0;
    conv_busy = 1'b0;
    rd_chan   = '0;
    repeat (3) step();
    check_eq("rst_conv_req", int'(conv_req), 0);
    check_eq("rst_conv_chan", int'(conv_chan), 0);
    check_eq("rst_rd_data", int'(rd_data), 0);
    check_eq("rst_frame_done", int'(frame_done), 0);
    check_eq("rst_timeout_err", int'(timeout_err), 0);
    rst_n = 1'b1;
    step();
    chk_bank("rst");
    rd_bank(3, v);
    check_eq("rd_oob3", v, 0);

    // Constant 100: two sweeps, 12 conversions each
    data_mode = 1;
    const_val = 100;
    f0 = frames; d0 = dones; ef0 = exp_frames;
    run_frames(2, "c100");
    check_eq("c100_dones", dones - d0, 24);
    check_eq("c100_model_frames", frames - f0, exp_frames - ef0);
    chk_bank("c100");
    rd_bank(15, v);
    check_eq("rd_oob15", v, 0);

    // Truncation: ch0 sees 1,2,3,4
    data_mode = 0;
    seq_v = '{1, 2, 3, 4};
    seq_token++;
    step(); step();
    run_frames(1, "seq");
    rd_bank(0, v);
    check_eq("seq_trunc", v, 2);
    chk_bank("seq");

    // Full scale and just-at-threshold
    data_mode = 1;
    const_val = 1023;
    run_frames(1, "full");
    chk_bank("full");
    const_val = 900;
    run_frames(1, "thr");
    chk_bank("thr");

    // Random data over several sweeps
    data_mode = 0;
    f0 = frames; ef0 = exp_frames;
    run_frames(3, "rand");
    check_eq("rand_model_frames", frames - f0, exp_frames - ef0);
    chk_bank("rand");

    // Timeout on the first ch1 request
    drop_ch = 1;
    drop_token++;
    t0 = tos; et0 = exp_tos; d0 = dones;
    run_frames(1, "to");
    check_eq("to_count", tos - t0, 1);
    check_eq("to_model_count", tos - t0, exp_tos - et0);
    check_eq("to_latency_ok", int'((to_cyc - drop_req_cyc) >= TO && (to_cyc - drop_req_cyc) <= TO + 2), 1);
    check_eq("to_rereq_chan", rereq_ch, 1);
    check_eq("to_dones", dones - d0, 12);
    chk_bank("to");

    // conv_busy held for 20 cycles in REQ
    conv_busy = 1'b1;
    scan_en   = 1'b1;
    r0 = reqs;
    repeat (20) step();
    check_eq("busy_no_req", reqs - r0, 0);
    conv_busy = 1'b0;
    fall = cyc;
    b = 0;
    while (reqs == r0 && b < 10) begin
      step();
      b++;
    end
    check_eq("busy_req_delay", last_req_cyc - fall, 1);
    run_frames(1, "busy");
    chk_bank("busy");

    // Abort on the first ch2 sample
    prev2 = exp_bank[2];
    f0 = frames;
    scan_en = 1'b1;
    b = 0;
    while (!(conv_req && conv_chan == 4'd2) && b < 2000) begin
      step();
      b++;
    end
    check_eq("abort_reached_ch2", int'(conv_req && conv_chan == 4'd2), 1);
    scan_en = 1'b0;
    repeat (10) step();
    r1 = reqs;
    repeat (20) step();
    check_eq("abort_no_req", reqs - r1, 0);
    check_eq("abort_no_frame", frames - f0, 0);
    check_eq("abort_chan_idle", int'(conv_chan), 0);
    clr_token++;
    step(); step();
    rd_bank(2, v);
    check_eq("abort_bank2_kept", v, prev2);
    chk_bank("abort");

    // Reset while a conversion is outstanding
    drop_ch = 0;
    drop_token++;
    r0 = reqs;
    scan_en = 1'b1;
    b = 0;
    while (reqs == r0 && b < 100) begin
      step();
      b++;
    end
    repeat (3) step();
    rd_chan = 4'd1;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_conv_req", int'(conv_req), 0);
    check_eq("mrst_conv_chan", int'(conv_chan), 0);
    check_eq("mrst_rd_data", int'(rd_data), 0);
    check_eq("mrst_frame_done", int'(frame_done), 0);
    check_eq("mrst_timeout_err", int'(timeout_err), 0);
    scan_en = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk_bank("mrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
